elastic_buffer: RTL
===================

ELASTIC_BUFFER -- requirements
Module: elastic_buffer

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, >=1.
REQ-002 Parameter DEPTH, default 2: number of entries; power of two and >=2; DEPTH=2 gives a full-throughput skid buffer.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset; assertion is asynchronous, deassertion is synchronous to clk (external synchroniser).
REQ-005 stall_i  input  1  freezes both ports while high.
REQ-006 flush_i  input  1  discards all stored entries.
REQ-007 rdy_o  output  1  upstream ready.
REQ-008 val_i  input  1  upstream valid.
REQ-009 d_i  input  WIDTH  upstream payload.
REQ-010 rdy_i  input  1  downstream ready.
REQ-011 val_o  output  1  downstream valid.
REQ-012 d_o  output  WIDTH  downstream payload, head entry.
REQ-013 count_o  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Function
REQ-014 rdy_o SHALL equal !full & !stall_i, with no combinational path from rdy_i or val_i to rdy_o.
REQ-015 val_o SHALL equal !empty & !stall_i.
REQ-016 push = val_i & rdy_o; pop = val_o & rdy_i; both are evaluated every cycle.
REQ-017 On push, d_i SHALL be written at the tail at the clock edge and become visible on d_o/val_o no earlier than the next cycle (1-cycle latency, no bypass).
REQ-018 d_o SHALL be a registered-storage read of the head entry (mux of flops), with no combinational path from d_i.
REQ-019 Simultaneous push and pop SHALL leave count_o unchanged and advance both pointers; sustained throughput is 1 beat/cycle for any DEPTH>=2.
REQ-020 When full, rdy_o SHALL be low even if pop occurs that cycle; the slot frees on the next cycle.
REQ-021 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 modulo DEPTH; full/empty SHALL derive from count, not from pointer equality.
REQ-022 count_o SHALL update as +1 on push-only, -1 on pop-only, and unchanged otherwise; it never exceeds DEPTH or underflows.
REQ-023 flush_i high SHALL set count to 0 and both pointers to 0 at the edge, overriding any push or pop that cycle; storage contents are not cleared.
REQ-024 stall_i high SHALL block push and pop via rdy_o/val_o; flush_i SHALL still act during stall.
REQ-025 Payload order SHALL be strictly FIFO; no entry is dropped or duplicated except by flush.

Reset
REQ-026 While reset_n is low: count_o=0, pointers=0, val_o=0, rdy_o=!stall_i; storage SHALL NOT be reset.
REQ-027 Reset assertion mid-transfer SHALL discard all entries immediately, without waiting for clk.
REQ-028 d_o SHALL read 0 during reset only when ELASTIC_BUFFER_ZERO_ON_INVALID_EN is defined.

Configuration
REQ-029 Macro ELASTIC_BUFFER_ZERO_ON_INVALID_EN defined: d_o SHALL be forced to all-zero whenever val_o is low, including during stall, when empty, and during reset.
REQ-030 Macro undefined: d_o SHALL present the head storage entry unconditionally, and its value is don't-care while val_o is low.

Structure
REQ-031 The shared primitives package prim_pkg SHALL hold the ptr-width and count-width helper functions (clog2-based) used here and by other primitives.
REQ-032 Pointer wrap logic SHALL be one sub-module, ring_ptr (parameter DEPTH; inputs clk, reset_n, clr, inc; output ptr), instantiated twice.
REQ-033 Storage SHALL be a flop array; no memory macro.

Verification (WIDTH=8, DEPTH=4)
REQ-034 Push 0x11,0x22,0x33,0x44 with rdy_i=0 -> count_o=4, rdy_o=0; then rdy_i=1 -> d_o reads 0x11,0x22,0x33,0x44 on consecutive cycles, and rdy_o returns high the cycle after the first pop.
REQ-035 Continuous val_i=1 and rdy_i=1 for 20 cycles with an incrementing payload -> output matches input 1 cycle later, count_o stays at 1, and the pointers wrap with no gaps.
REQ-036 Hold 3 entries, then pulse stall_i for 2 cycles with val_i=rdy_i=1 -> val_o=0 and rdy_o=0 during the stall, and count_o stays at 3.
REQ-037 Hold 3 entries, then assert flush_i together with push of 0x55 -> count_o=0 next cycle, val_o=0, and 0x55 is not delivered.
REQ-038 Hold 2 entries, then drop reset_n asynchronously between edges -> val_o=0 and count_o=0 immediately; after release the first push of 0xA5 appears first.
REQ-039 Run with ELASTIC_BUFFER_ZERO_ON_INVALID_EN defined, buffer empty, with 0xFF previously stored -> d_o=0x00; without the macro, d_o is not checked.

Source files
------------

// File: rtl/prim_pkg.sv
// Shared primitive helpers: pointer and occupancy-counter widths derived from an entry count.
package prim_pkg;

    // Index width for a ring of `depth` entries; a single-entry ring still needs one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width able to hold every occupancy value 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ring_ptr.sv
// Modulo-DEPTH ring pointer with synchronous clear and increment.
module ring_ptr
    import prim_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clr,
    input  logic                        inc,
    output logic [ptr_width(DEPTH)-1:0] ptr
);

    localparam int            PW   = ptr_width(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/elastic_buffer.sv
// Valid/ready elastic buffer (DEPTH=2 is a full-throughput skid buffer) with stall and flush.
// Optional macro ELASTIC_BUFFER_ZERO_ON_INVALID_EN forces d_o to zero whenever val_o is low.
module elastic_buffer
    import prim_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          stall_i,
    input  logic                          flush_i,
    output logic                          rdy_o,
    input  logic                          val_i,
    input  logic [WIDTH-1:0]              d_i,
    input  logic                          rdy_i,
    output logic                          val_o,
    output logic [WIDTH-1:0]              d_o,
    output logic [count_width(DEPTH)-1:0] count_o
);

    localparam int            PW       = ptr_width(DEPTH);
    localparam int            CW       = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Occupancy alone decides full/empty, so ready never depends on rdy_i or val_i.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign rdy_o = !full && !stall_i;
    assign val_o = !empty && !stall_i;
    assign push  = val_i && rdy_o;
    assign pop   = val_o && rdy_i;

    ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush_i),
        .inc     (push),
        .ptr     (wr_ptr)
    );

    ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush_i),
        .inc     (pop),
        .ptr     (rd_ptr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (flush_i) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CW'(1);
        end else if (pop && !push) begin
            count <= count - CW'(1);
        end
    end

    // NOTE: payload storage has no reset; occupancy already marks stale entries invalid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= d_i;
        end
    end

    assign count_o = count;

`ifdef ELASTIC_BUFFER_ZERO_ON_INVALID_EN
    assign d_o = val_o ? mem[rd_ptr] : '0;
`else
    assign d_o = mem[rd_ptr];
`endif

endmodule
